// File: rtl/minesweeper_pkg.sv
// Shared constants and types for the Minesweeper input path.
package minesweeper_pkg;
  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

  typedef logic [4:0] key_code_t;
endpackage

// File: rtl/btn_debounce_cell.sv
// One matrix key: agree counter plus debounced state bit.
module btn_debounce_cell #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  input  logic commit_allow,
  output logic state,
  output logic qualified,
  output logic rise,
  output logic fall
);
  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

  logic [3:0] cnt_q;
  logic [3:0] cnt_inc;
  logic       state_q;
  logic       commit;

  // A key that qualified but lost arbitration stays parked at CNT_MAX.
  assign cnt_inc   = (raw != state_q) ? ((cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1) : 4'd0;
  assign qualified = sample_en && (cnt_inc == CNT_MAX);
  assign commit    = qualified && commit_allow;
  assign rise      = commit && !state_q;
  assign fall      = commit && state_q;
  assign state     = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else if (sample_en) begin
      if (commit) begin
        cnt_q   <= '0;
        state_q <= ~state_q;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end
endmodule

// File: rtl/btn_matrix_scanner.sv
// Scans the 5x4 button matrix column by column and emits debounced press/release events.
module btn_matrix_scanner
  import minesweeper_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  col_n,
  input  logic [3:0]  row_n,
  output logic [19:0] key_state,
  output logic [4:0]  key_code,
  output logic        key_press,
  output logic        key_release
);
  localparam int                 DWELL_W    = $clog2(SCAN_DIV);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [2:0]         COL_LAST   = 3'(NUM_COLS - 1);

  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [2:0]          col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_n_q, col_n_d;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q, row;
  logic                sample_tick;
  logic [NUM_KEYS-1:0] qual, allow, rise, fall;
  key_code_t           key_code_q, key_code_d;
  logic                key_press_q, key_release_q;

  // Sampling on the last dwell cycle leaves settling time plus synchronizer delay.
  assign sample_tick = (dwell_q == DWELL_LAST);
  assign row         = ~row_s2_q;

  always_comb begin
    dwell_d   = dwell_q + 1'b1;
    col_idx_d = col_idx_q;
    col_n_d   = col_n_q;
    if (sample_tick) begin
      dwell_d   = '0;
      col_idx_d = (col_idx_q == COL_LAST) ? 3'd0 : col_idx_q + 3'd1;
      col_n_d   = ~(5'(1) << col_idx_d);
    end
  end

  // Lowest qualified row in the sampled column wins; only one column samples at a time.
  always_comb begin
    allow = '1;
    for (int c = 0; c < NUM_COLS; c++)
      for (int r = 1; r < NUM_ROWS; r++)
        for (int j = 0; j < r; j++)
          if (qual[c*NUM_ROWS + j]) allow[c*NUM_ROWS + r] = 1'b0;
  end

  always_comb begin
    key_code_d = key_code_q;
    for (int k = 0; k < NUM_KEYS; k++)
      if (rise[k] || fall[k]) key_code_d = key_code_t'(k);
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      btn_debounce_cell #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_cell (
        .clk         (clk),
        .reset       (reset),
        .sample_en   (sample_tick && (col_idx_q == 3'(c))),
        .raw         (row[r]),
        .commit_allow(allow[c*NUM_ROWS + r]),
        .state       (key_state[c*NUM_ROWS + r]),
        .qualified   (qual[c*NUM_ROWS + r]),
        .rise        (rise[c*NUM_ROWS + r]),
        .fall        (fall[c*NUM_ROWS + r])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q       <= '0;
      col_idx_q     <= '0;
      col_n_q       <= 5'b11110;
      row_s1_q      <= '1;
      row_s2_q      <= '1;
      key_code_q    <= '0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      dwell_q       <= dwell_d;
      col_idx_q     <= col_idx_d;
      col_n_q       <= col_n_d;
      row_s1_q      <= row_n;
      row_s2_q      <= row_s1_q;
      key_code_q    <= key_code_d;
      key_press_q   <= |rise;
      key_release_q <= |fall;
    end
  end

  assign col_n       = col_n_q;
  assign key_code    = key_code_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
endmodule

// File: tb/tb_btn_matrix_scanner.sv
// Directed bench for btn_matrix_scanner with a behavioural button matrix (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_btn_matrix_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  col_n;
  logic [3:0]  row_n;
  logic [19:0] key_state;
  logic [4:0]  key_code;
  logic        key_press;
  logic        key_release;

  logic [19:0] pressed = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          both_cnt = 0;
  int          ev_code[$];
  int          ev_press[$];
  int          ev_cyc[$];

  btn_matrix_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col_n      (col_n),
    .row_n      (row_n),
    .key_state  (key_state),
    .key_code   (key_code),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key pulls its row low only while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4 + r] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_press && key_release) both_cnt++;
    if (key_press || key_release) begin
      ev_code.push_back(int'(key_code));
      ev_press.push_back(key_press ? 1 : 0);
      ev_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_ev();
    ev_code.delete();
    ev_press.delete();
    ev_cyc.delete();
  endtask

  task automatic wait_events(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (ev_code.size() < n && b > 0) begin
      tick(1);
      b--;
    end
    chk(tag, 32'(ev_code.size()), 32'(n));
  endtask

  initial begin
    int          r0;
    logic [4:0]  exp_col;
    logic [4:0]  one5;
    int          found3;
    int          found7;

    // Reset values
    #1 reset = 1'b0;
    tick(2);
    chk("rst_col_n", 32'(col_n), 32'h1E);
    chk("rst_state", 32'(key_state), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_press", 32'(key_press), 32'h0);
    chk("rst_release", 32'(key_release), 32'h0);

    // Column walk with all rows released
    reset = 1'b1;
    one5 = 5'b00001;
    for (int i = 0; i < 21; i++) begin
      tick(1);
      exp_col = ~(one5 << (((i + 1) / 4) % 5));
      chk("walk_col_n", 32'(col_n), 32'(exp_col));
    end
    tick(60);
    chk("walk_no_events", 32'(ev_code.size()), 32'h0);

    // Clean press and release of key 9
    clear_ev();
    pressed[9] = 1'b1;
    wait_events("press9_arrived", 1, 85);
    if (ev_code.size() >= 1) begin
      chk("press9_code", 32'(ev_code[0]), 32'd9);
      chk("press9_kind", 32'(ev_press[0]), 32'd1);
    end
    chk("press9_state", 32'(key_state), 32'h00200);
    tick(60);
    chk("press9_single", 32'(ev_code.size()), 32'd1);
    clear_ev();
    pressed[9] = 1'b0;
    wait_events("rel9_arrived", 1, 85);
    if (ev_code.size() >= 1) begin
      chk("rel9_code", 32'(ev_code[0]), 32'd9);
      chk("rel9_kind", 32'(ev_press[0]), 32'd0);
    end
    chk("rel9_state", 32'(key_state), 32'h0);

    // Bounce: two scans down, one up, twice
    clear_ev();
    for (int k = 0; k < 2; k++) begin
      pressed[9] = 1'b1;
      tick(40);
      pressed[9] = 1'b0;
      tick(20);
    end
    tick(80);
    chk("bounce_no_events", 32'(ev_code.size()), 32'h0);
    chk("bounce_state", 32'(key_state), 32'h0);

    // Same-column simultaneous press of keys 8 and 10
    clear_ev();
    pressed[8]  = 1'b1;
    pressed[10] = 1'b1;
    wait_events("simul_arrived", 2, 130);
    if (ev_code.size() >= 2) begin
      chk("simul_first", 32'(ev_code[0]), 32'd8);
      chk("simul_second", 32'(ev_code[1]), 32'd10);
      chk("simul_gap", 32'(ev_cyc[1] - ev_cyc[0]), 32'd20);
      chk("simul_kinds", 32'(ev_press[0] + ev_press[1]), 32'd2);
    end
    chk("simul_state", 32'(key_state), 32'h00500);
    clear_ev();
    pressed[8]  = 1'b0;
    pressed[10] = 1'b0;
    wait_events("simul_rel_arrived", 2, 130);
    chk("simul_rel_state", 32'(key_state), 32'h0);

    // Reset in the middle of debouncing key 0
    clear_ev();
    pressed[0] = 1'b1;
    tick(40);
    chk("mid_no_press", 32'(ev_code.size()), 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_col_n", 32'(col_n), 32'h1E);
    chk("mid_rst_code", 32'(key_code), 32'h0);
    chk("mid_rst_state", 32'(key_state), 32'h0);
    chk("mid_rst_press", 32'(key_press), 32'h0);
    tick(3);
    clear_ev();
    reset = 1'b1;
    r0 = cyc;
    wait_events("mid_press_arrived", 1, 100);
    if (ev_code.size() >= 1) begin
      chk("mid_press_code", 32'(ev_code[0]), 32'd0);
      chk("mid_press_latency", 32'(ev_cyc[0] - r0), 32'd44);
    end

    // Opposite events in different columns
    clear_ev();
    pressed[0] = 1'b0;
    wait_events("rel0_arrived", 1, 85);
    clear_ev();
    pressed[3] = 1'b1;
    wait_events("press3_arrived", 1, 85);
    chk("press3_state", 32'(key_state), 32'h00008);
    clear_ev();
    pressed[3] = 1'b0;
    pressed[7] = 1'b1;
    wait_events("opp_arrived", 2, 130);
    found3 = 0;
    found7 = 0;
    for (int i = 0; i < ev_code.size(); i++) begin
      if (ev_code[i] == 3 && ev_press[i] == 0) found3++;
      if (ev_code[i] == 7 && ev_press[i] == 1) found7++;
    end
    chk("opp_release3", 32'(found3), 32'd1);
    chk("opp_press7", 32'(found7), 32'd1);
    if (ev_cyc.size() >= 2)
      chk("opp_separate", 32'(ev_cyc[0] != ev_cyc[1]), 32'd1);
    chk("opp_state", 32'(key_state), 32'h00080);
    chk("never_both", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
